// File: rtl/perceptron_sched.sv
// perceptron_sched
//   Command scheduler between a UART byte interface and a perceptron MAC
//   datapath. Host packets write the weight/input bank or start a MAC pass
//   over all N_IN entries; every command answers with one reply byte.
//   Optional build macro: RAW_RESULT_EN. When defined, RUN replies with the
//   raw accumulator as two bytes (mac_acc[15:8] then mac_acc[7:0]). When it
//   is undefined, RUN replies with a single activation byte (0x01 / 0x00).
module perceptron_sched #(
  parameter int N_IN    = 4,      // weight/input pairs (2..16)
  parameter int AW      = 2,      // bank address width, >= clog2(N_IN)
  parameter int TIMEOUT = 65535   // idle cycles tolerated inside a packet
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_busy,
  output logic [AW-1:0]       bank_addr,
  output logic [7:0]          bank_wdata,
  output logic                bank_we,
  output logic                bank_sel,
  output logic                mac_clr,
  output logic                mac_en,
  input  logic signed [15:0]  mac_acc,
  output logic                busy,
  output logic                overrun
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [7:0]    OP_WR_W   = 8'h01;
  localparam logic [7:0]    OP_WR_X   = 8'h02;
  localparam logic [7:0]    OP_RUN    = 8'h03;
  localparam logic [7:0]    REPLY_ACK = 8'hAA;
  localparam logic [7:0]    REPLY_ERR = 8'hEE;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N_IN - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_VAL,
    S_WRITE,
    S_CLR,
    S_READ,
    S_SETTLE,
    S_RESP,
    S_TX_GUARD,
    S_TX_WAIT
  } state_t;

  state_t          state_q;
  logic [TW-1:0]   tmo_q;        // idle cycles since the last byte of a packet
  logic [7:0]      addr_q;       // address byte of the packet in flight
  logic            sel_q;        // 0 = weight, 1 = input, taken from opcode bit 1
  logic            run_q;        // reply comes from the accumulator, not reply_q
  logic            more_q;       // another reply byte follows the current one
  logic [7:0]      reply_q;      // next byte to transmit for non-result replies
  logic [7:0]      tx_data_q;
  logic            tx_start_q;
  logic [AW-1:0]   bank_addr_q;
  logic [7:0]      bank_wdata_q;
  logic            bank_we_q;
  logic            bank_sel_q;
  logic            mac_clr_q;
  logic            mac_en_q;
  logic            busy_q;
  logic            overrun_q;

  // Command FSM: packet parsing, bank writes, MAC sequencing and reply handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      addr_q       <= '0;
      sel_q        <= 1'b0;
      run_q        <= 1'b0;
      more_q       <= 1'b0;
      reply_q      <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
      bank_we_q    <= 1'b0;
      bank_sel_q   <= 1'b0;
      mac_clr_q    <= 1'b0;
      mac_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge register values regardless of statement order.
      // NOTE: single-cycle strobes default low here; a state that needs one
      // overrides the default further down, which guarantees a 1-cycle pulse.
      tx_start_q <= 1'b0;
      bank_we_q  <= 1'b0;
      mac_clr_q  <= 1'b0;
      mac_en_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            busy_q <= 1'b1;
            tmo_q  <= '0;
            run_q  <= 1'b0;
            more_q <= 1'b0;
            case (rx_data)
              OP_WR_W, OP_WR_X: begin
                sel_q   <= rx_data[1];
                state_q <= S_GET_ADDR;
              end
              OP_RUN: begin
                run_q     <= 1'b1;
                mac_clr_q <= 1'b1;
                state_q   <= S_CLR;
              end
              default: begin
                reply_q <= REPLY_ERR;
                state_q <= S_RESP;
              end
            endcase
          end
        end

        // A byte arriving in the expiry cycle wins over the timeout.
        S_GET_ADDR, S_GET_VAL: begin
          if (rx_valid) begin
            tmo_q <= '0;
            if (state_q == S_GET_ADDR) begin
              addr_q  <= rx_data;
              state_q <= S_GET_VAL;
            end else begin
              if (int'(addr_q) < N_IN) begin
                bank_we_q    <= 1'b1;
                bank_addr_q  <= addr_q[AW-1:0];
                bank_wdata_q <= rx_data;
                bank_sel_q   <= sel_q;
                reply_q      <= REPLY_ACK;
              end else begin
                reply_q <= REPLY_ERR;
              end
              state_q <= S_WRITE;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end

        // bank_we is high during this cycle only.
        S_WRITE: begin
          state_q <= S_RESP;
        end

        // mac_clr is high during this cycle; the read sweep starts at entry 0.
        S_CLR: begin
          bank_addr_q <= '0;
          state_q     <= S_READ;
        end

        // One address per cycle; data returns a cycle later, hence mac_en lags.
        S_READ: begin
          mac_en_q <= 1'b1;
          if (bank_addr_q == ADDR_LAST) begin
            state_q <= S_SETTLE;
          end else begin
            bank_addr_q <= bank_addr_q + AW'(1);
          end
        end

        // Last mac_en cycle; the accumulator is final once RESP is reached.
        S_SETTLE: begin
          state_q <= S_RESP;
        end

        S_RESP: begin
          if (!tx_busy) begin
            tx_start_q <= 1'b1;
            state_q    <= S_TX_GUARD;
            if (run_q) begin
`ifdef RAW_RESULT_EN
              tx_data_q <= mac_acc[15:8];
              reply_q   <= mac_acc[7:0];
              more_q    <= 1'b1;
              run_q     <= 1'b0;
`else
              tx_data_q <= (mac_acc > 16'sd0) ? 8'h01 : 8'h00;
`endif
            end else begin
              tx_data_q <= reply_q;
            end
          end
        end

        // Gives the transmitter one cycle to raise tx_busy after tx_start.
        S_TX_GUARD: begin
          state_q <= S_TX_WAIT;
        end

        S_TX_WAIT: begin
          if (!tx_busy) begin
            if (more_q) begin
              more_q  <= 1'b0;
              state_q <= S_RESP;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Bytes are dropped outside the parser states; only the run and reply
      // phases flag the loss, a byte lost during WRITE is silently ignored.
      if (rx_valid && (state_q inside {S_CLR, S_READ, S_SETTLE, S_RESP,
                                       S_TX_GUARD, S_TX_WAIT})) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;
  assign bank_we    = bank_we_q;
  assign bank_sel   = bank_sel_q;
  assign mac_clr    = mac_clr_q;
  assign mac_en     = mac_en_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_perceptron_sched.sv
// tb_perceptron_sched
//   Scoreboard bench for perceptron_sched. A bank + MAC model and a UART
//   transmitter model surround the DUT; expected reply bytes are queued when
//   each command is driven and popped when the DUT raises tx_start.
module tb_perceptron_sched;

  localparam int N_IN    = 4;
  localparam int AW      = 2;
  localparam int TIMEOUT = 32;

  logic                clk      = 1'b0;
  logic                rst      = 1'b1;
  logic [7:0]          rx_data  = '0;
  logic                rx_valid = 1'b0;
  logic [7:0]          tx_data;
  logic                tx_start;
  logic                tx_busy;
  logic [AW-1:0]       bank_addr;
  logic [7:0]          bank_wdata;
  logic                bank_we;
  logic                bank_sel;
  logic                mac_clr;
  logic                mac_en;
  logic signed [15:0]  mac_acc;
  logic                busy;
  logic                overrun;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int sent_cyc = 0;

  logic [7:0] sb_q[$];
  int         tx_cycs[$];
  logic [7:0] mon_exp;

  logic signed [7:0] wexp [N_IN] = '{default: 8'sd0};
  logic signed [7:0] xexp [N_IN] = '{default: 8'sd0};

  perceptron_sched #(.N_IN(N_IN), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_we    (bank_we),
    .bank_sel   (bank_sel),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .mac_acc    (mac_acc),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter: busy for a few cycles after each tx_start, plus a
  // bench-controlled hold.
  int   uart_cnt  = 0;
  logic hold_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start)          uart_cnt <= 6;
    else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
  end
  assign tx_busy = hold_busy || (uart_cnt != 0);

  // Weight/input bank with 1-cycle read latency and the MAC accumulator.
  logic [7:0]         w_mem [N_IN] = '{default: 8'h00};
  logic [7:0]         x_mem [N_IN] = '{default: 8'h00};
  logic signed [7:0]  rd_w    = '0;
  logic signed [7:0]  rd_x    = '0;
  logic [AW-1:0]      rd_addr = '0;
  logic signed [15:0] acc     = '0;
  int                 clr_cnt = 0;
  int                 en_cnt  = 0;
  int                 we_cnt  = 0;
  logic [AW-1:0]      we_addr = '0;
  logic [7:0]         we_data = '0;
  logic               we_sel  = 1'b0;
  int                 en_addrs[$];

  always @(posedge clk) begin
    if (bank_we) begin
      if (bank_sel) x_mem[bank_addr] <= bank_wdata;
      else          w_mem[bank_addr] <= bank_wdata;
      we_cnt  <= we_cnt + 1;
      we_addr <= bank_addr;
      we_data <= bank_wdata;
      we_sel  <= bank_sel;
    end
    rd_w    <= w_mem[bank_addr];
    rd_x    <= x_mem[bank_addr];
    rd_addr <= bank_addr;
    if (mac_clr) begin
      acc     <= '0;
      clr_cnt <= clr_cnt + 1;
    end else if (mac_en) begin
      acc    <= acc + rd_w * rd_x;
      en_cnt <= en_cnt + 1;
      en_addrs.push_back(int'(rd_addr));
    end
  end
  assign mac_acc = acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reply monitor: pops the scoreboard on each transmit request.
  always @(negedge clk) begin
    if (tx_start) begin
      check("tx_while_busy", 32'(tx_busy), 32'd0);
      if (sb_q.size() == 0) begin
        check("tx_unexpected", sb_q.size(), 32'd1);
      end else begin
        mon_exp = sb_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(mon_exp));
      end
      tx_cycs.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    sent_cyc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_drained"}, sb_q.size(), 32'd0);
  endtask

  function automatic int model_sum();
    int s;
    s = 0;
    for (int i = 0; i < N_IN; i++) s += int'(wexp[i]) * int'(xexp[i]);
    return s;
  endfunction

  task automatic push_result(input int sum);
    logic signed [15:0] s16;
    s16 = 16'(sum);
`ifdef RAW_RESULT_EN
    sb_q.push_back(s16[15:8]);
    sb_q.push_back(s16[7:0]);
`else
    sb_q.push_back((s16 > 16'sd0) ? 8'h01 : 8'h00);
`endif
  endtask

  task automatic write_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] v);
    if (int'(a) < N_IN) begin
      sb_q.push_back(8'hAA);
      if (op == 8'h01) wexp[a[AW-1:0]] = v;
      else             xexp[a[AW-1:0]] = v;
    end else begin
      sb_q.push_back(8'hEE);
    end
    send_byte(op);
    send_byte(a);
    send_byte(v);
    wait_idle("wr");
  endtask

  task automatic run_cmd(input string tag);
    int sum, clr0, en0, base, t0, lat;
    logic signed [15:0] s16;
    sum  = model_sum();
    s16  = 16'(sum);
    push_result(sum);
    clr0 = clr_cnt;
    en0  = en_cnt;
    base = en_addrs.size();
    t0   = tx_cycs.size();
    send_byte(8'h03);
    wait_idle(tag);
    check({tag, "_clr_pulses"}, 32'(clr_cnt - clr0), 32'd1);
    check({tag, "_en_pulses"}, 32'(en_cnt - en0), 32'(N_IN));
    for (int i = 0; i < N_IN; i++) begin
      check({tag, "_read_addr"},
            (base + i < en_addrs.size()) ? 32'(en_addrs[base + i]) : 32'hFFFF_FFFF, 32'(i));
    end
    lat = (tx_cycs.size() > t0) ? tx_cycs[t0] - sent_cyc : -1;
    check({tag, "_latency"}, 32'(lat), 32'(N_IN + 3));
    check({tag, "_acc"}, 32'(acc), 32'(s16));
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: bench did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int we0, t0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({tx_data, tx_start, bank_addr, bank_wdata, bank_we, bank_sel,
               mac_clr, mac_en, busy, overrun}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Weight write: one bank_we pulse with the packet's address and data.
    we0 = we_cnt;
    write_cmd(8'h01, 8'h02, 8'h7F);
    check("wr_we_pulses", 32'(we_cnt - we0), 32'd1);
    check("wr_addr", 32'(we_addr), 32'd2);
    check("wr_data", 32'(we_data), 32'h7F);
    check("wr_sel", 32'(we_sel), 32'd0);

    // Out-of-range address: no write, error reply.
    we0 = we_cnt;
    write_cmd(8'h02, 8'h05, 8'h11);
    check("oob_no_we", 32'(we_cnt - we0), 32'd0);

    // Unknown opcode: error reply.
    sb_q.push_back(8'hEE);
    send_byte(8'h55);
    wait_idle("bad_op");

    // W = {1,2,3,4}, X = {1,1,1,1}: acc 10 -> activation 1.
    for (int i = 0; i < N_IN; i++) write_cmd(8'h01, 8'(i), 8'(i + 1));
    we0 = we_cnt;
    for (int i = 0; i < N_IN; i++) write_cmd(8'h02, 8'(i), 8'h01);
    check("x_we_pulses", 32'(we_cnt - we0), 32'(N_IN));
    check("x_sel", 32'(we_sel), 32'd1);
    run_cmd("run_pos");

    // Back-to-back byte landing in WRITE is dropped without overrun.
    sb_q.push_back(8'hAA);
    wexp[3] = 8'sd5;
    send_byte(8'h01);
    send_byte(8'h03);
    send_byte(8'h05);
    send_byte(8'hAB);
    wait_idle("wr_drop");
    check("no_overrun_in_write", 32'(overrun), 32'd0);
    run_cmd("run_after_drop");

    // Timeout: partial packet is discarded silently at exactly TIMEOUT cycles.
    t0 = tx_cycs.size();
    send_byte(8'h01);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("tmo_busy_at_expiry", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo_back_to_idle", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("tmo_no_reply", 32'(tx_cycs.size() - t0), 32'd0);
    run_cmd("run_after_tmo");

    // Byte arriving in the expiry cycle is accepted: W[0] = -1.
    sb_q.push_back(8'hAA);
    wexp[0] = -8'sd1;
    send_byte(8'h01);
    repeat (TIMEOUT - 1) @(negedge clk);
    send_byte(8'h00);
    send_byte(8'hFF);
    wait_idle("tmo_accept");
    for (int i = 1; i < N_IN; i++) write_cmd(8'h01, 8'(i), 8'h00);
    run_cmd("run_neg");

    // Zero accumulator gives a 0x00 activation.
    write_cmd(8'h01, 8'h00, 8'h00);
    run_cmd("run_zero");

    // tx_busy held at RESP: no tx_start; a byte during RUN sets overrun.
    write_cmd(8'h01, 8'h01, 8'h03);
    hold_busy = 1'b1;
    push_result(model_sum());
    t0 = tx_cycs.size();
    send_byte(8'h03);
    @(negedge clk);
    send_byte(8'h5A);
    repeat (100) @(negedge clk);
    check("hold_no_tx", 32'(tx_cycs.size() - t0), 32'd0);
    check("hold_busy", 32'(busy), 32'd1);
    check("overrun_set", 32'(overrun), 32'd1);
    hold_busy = 1'b0;
    wait_idle("hold");
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset mid-RUN: idle next cycle, overrun cleared, no reply.
    t0 = tx_cycs.size();
    send_byte(8'h03);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_reply", 32'(tx_cycs.size() - t0), 32'd0);
    check("rst_still_idle", 32'(busy), 32'd0);
    run_cmd("run_recover");

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
